ir_prefetch_queue: RTL and testbench

Parametrised instruction register for the von Neumann CPU, fronted by a DEPTH-entry prefetch FIFO. The memory/fetch side pushes instruction words with a valid/ready handshake. The control unit pulls the oldest word into the instruction register with LOAD, or discards all prefetched words with FLUSH on a jump. The register contents are split into opcode and operand fields for the decoder.

---
 rtl/ir_prefetch_queue.sv | 105 ++++++++++
 tb/tb_ir_prefetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, split into opcode/operand fields.
// Latency: a pushed word is loadable on the next edge; LOAD updates DATA_OUT on the same edge.
// Backpressure: FETCH_READY drops when the FIFO is full; LOAD on an empty FIFO raises STALL.
module ir_prefetch_queue #(
   parameter int WIDTH     = 12,
   parameter int OPC_WIDTH = 4,
   parameter int DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         REST,
   input  logic [WIDTH-1:0]             FETCH_DATA,
   input  logic                         FETCH_VALID,
   output logic                         FETCH_READY,
   input  logic                         LOAD,
   input  logic                         FLUSH,
   output logic [WIDTH-1:0]             DATA_OUT,
   output logic [OPC_WIDTH-1:0]         OPCODE,
   output logic [WIDTH-OPC_WIDTH-1:0]   OPERAND,
   output logic                         IR_VALID,
   output logic                         STALL,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] ir_q;
   logic             ir_valid_q;

   logic             push;
   logic             pop;
   logic             empty;

   // Handshake qualifiers; FLUSH overrides both push and pop in the same cycle.
   always_comb begin
      empty       = (count_q == '0);
      FETCH_READY = (count_q < FULL_COUNT);
      push        = FETCH_VALID && FETCH_READY && !FLUSH;
      pop         = LOAD && !empty && !FLUSH;
      STALL       = LOAD && empty && !FLUSH;
   end

   // Storage array write; contents are left stale on reset/flush since the pointers hide them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= FETCH_DATA;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge REST) begin
      if (!REST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (FLUSH) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Instruction register: loads the FIFO head on a pop, invalidates on a stalled LOAD or FLUSH.
   always_ff @(posedge clk or negedge REST) begin
      if (!REST) begin
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else if (FLUSH) begin
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else if (pop) begin
         ir_q       <= mem[rptr_q];
         ir_valid_q <= 1'b1;
      end else if (LOAD) begin
         ir_valid_q <= 1'b0;
      end
   end

   // Decoder-facing field split of the instruction register.
   always_comb begin
      DATA_OUT = ir_q;
      OPCODE   = ir_q[WIDTH-1 -: OPC_WIDTH];
      OPERAND  = ir_q[WIDTH-OPC_WIDTH-1:0];
      IR_VALID = ir_valid_q;
      COUNT    = count_q;
   end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
module tb_ir_prefetch_queue;

   localparam int WIDTH = 12;
   localparam int OPC_WIDTH = 4;
   localparam int DEPTH = 4;

   logic                       clk = 1'b0;
   logic                       REST = 1'b0;
   logic [WIDTH-1:0]           FETCH_DATA = '0;
   logic                       FETCH_VALID = 1'b0;
   logic                       FETCH_READY;
   logic                       LOAD = 1'b0;
   logic                       FLUSH = 1'b0;
   logic [WIDTH-1:0]           DATA_OUT;
   logic [OPC_WIDTH-1:0]       OPCODE;
   logic [WIDTH-OPC_WIDTH-1:0] OPERAND;
   logic                       IR_VALID;
   logic                       STALL;
   logic [2:0]                 COUNT;

   int n_cmp = 0;
   int n_bad = 0;

   ir_prefetch_queue #(.WIDTH(WIDTH), .OPC_WIDTH(OPC_WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .REST(REST),
      .FETCH_DATA(FETCH_DATA), .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
      .LOAD(LOAD), .FLUSH(FLUSH),
      .DATA_OUT(DATA_OUT), .OPCODE(OPCODE), .OPERAND(OPERAND),
      .IR_VALID(IR_VALID), .STALL(STALL), .COUNT(COUNT)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of words plus the register contents.
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_data = '0;
   logic             m_valid = 1'b0;

   always @(posedge clk or negedge REST) begin
      if (!REST) begin
         mq.delete();
         m_data  <= '0;
         m_valid <= 1'b0;
      end else if (FLUSH) begin
         mq.delete();
         m_data  <= '0;
         m_valid <= 1'b0;
      end else begin
         int sz;
         sz = mq.size();
         if (LOAD && sz > 0) begin
            m_data  <= mq.pop_front();
            m_valid <= 1'b1;
         end else if (LOAD) begin
            m_valid <= 1'b0;
         end
         if (FETCH_VALID && sz < DEPTH) mq.push_back(FETCH_DATA);
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] w;
      w = m_data;
      chk("cmp_data", DATA_OUT, w);
      chk("cmp_opcode", OPCODE, w[WIDTH-1 -: OPC_WIDTH]);
      chk("cmp_operand", OPERAND, w[WIDTH-OPC_WIDTH-1:0]);
      chk("cmp_valid", IR_VALID, m_valid);
      chk("cmp_count", COUNT, mq.size());
      chk("cmp_ready", FETCH_READY, mq.size() < DEPTH);
      chk("cmp_stall", STALL, LOAD && mq.size() == 0 && !FLUSH);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ld, input logic fl);
      FETCH_VALID = v;
      FETCH_DATA  = d;
      LOAD        = ld;
      FLUSH       = fl;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_data", DATA_OUT, 12'h000);
      chk("rst_valid", IR_VALID, 1'b0);
      chk("rst_count", COUNT, 3'd0);
      chk("rst_ready", FETCH_READY, 1'b1);
      chk("rst_stall_idle", STALL, 1'b0);
      LOAD = 1'b1;
      #1;
      chk("rst_stall_load", STALL, 1'b1);
      LOAD = 1'b0;
      @(posedge clk);
      #1;
      REST = 1'b1;

      // In-order load
      drive(1, 12'h105, 0, 0); tick();
      drive(1, 12'h2A0, 0, 0); tick();
      drive(1, 12'h3FF, 0, 0); tick();
      chk("ord_count3", COUNT, 3'd3);
      drive(0, 12'h000, 1, 0); tick();
      chk("ord_d0", DATA_OUT, 12'h105); chk("ord_op0", OPCODE, 4'h1);
      chk("ord_arg0", OPERAND, 8'h05);  chk("ord_v0", IR_VALID, 1'b1);
      tick();
      chk("ord_d1", DATA_OUT, 12'h2A0); chk("ord_op1", OPCODE, 4'h2);
      chk("ord_arg1", OPERAND, 8'hA0);  chk("ord_v1", IR_VALID, 1'b1);
      tick();
      chk("ord_d2", DATA_OUT, 12'h3FF); chk("ord_op2", OPCODE, 4'h3);
      chk("ord_arg2", OPERAND, 8'hFF);  chk("ord_v2", IR_VALID, 1'b1);
      chk("ord_count0", COUNT, 3'd0);

      // Empty LOAD with a same-cycle push: no bypass
      drive(1, 12'h777, 1, 0);
      #1;
      chk("empty_stall", STALL, 1'b1);
      tick();
      chk("empty_hold", DATA_OUT, 12'h3FF);
      chk("empty_valid", IR_VALID, 1'b0);
      chk("empty_count", COUNT, 3'd1);
      drive(0, 12'h000, 1, 0); tick();
      chk("empty_next", DATA_OUT, 12'h777);
      chk("empty_next_v", IR_VALID, 1'b1);

      // Full boundary
      for (int i = 1; i <= 4; i++) begin
         drive(1, 12'(i), 0, 0); tick();
      end
      chk("full_ready", FETCH_READY, 1'b0);
      chk("full_count", COUNT, 3'd4);
      drive(1, 12'h5AA, 0, 0); tick();
      chk("full_reject", COUNT, 3'd4);
      drive(1, 12'h5AA, 1, 0); tick();
      chk("full_pop", DATA_OUT, 12'h001);
      chk("full_pop_cnt", COUNT, 3'd3);
      chk("full_ready2", FETCH_READY, 1'b1);
      drive(1, 12'h5AA, 0, 0); tick();
      chk("full_accept", COUNT, 3'd4);
      drive(0, 12'h000, 1, 0); tick(); chk("full_d2", DATA_OUT, 12'h002);
      tick(); chk("full_d3", DATA_OUT, 12'h003);
      tick(); chk("full_d4", DATA_OUT, 12'h004);
      tick(); chk("full_d5", DATA_OUT, 12'h5AA);

      // Flush priority
      drive(1, 12'h111, 0, 0); tick();
      drive(1, 12'h222, 0, 0); tick();
      drive(1, 12'h333, 0, 0); tick();
      chk("fl_count3", COUNT, 3'd3);
      drive(1, 12'h6B1, 1, 1);
      #1;
      chk("fl_stall", STALL, 1'b0);
      tick();
      chk("fl_count", COUNT, 3'd0);
      chk("fl_data", DATA_OUT, 12'h000);
      chk("fl_valid", IR_VALID, 1'b0);
      drive(0, 12'h000, 0, 0);

      // Wrap-around stream with COUNT held at 2
      drive(1, 12'h001, 0, 0); tick();
      drive(1, 12'h002, 0, 0); tick();
      for (int k = 3; k <= 10; k++) begin
         drive(1, 12'(k), 1, 0); tick();
         chk("wrap_data", DATA_OUT, 32'(k - 2));
         chk("wrap_count", COUNT, 3'd2);
      end
      drive(0, 12'h000, 1, 0); tick(); chk("wrap_d9", DATA_OUT, 12'h009);
      tick(); chk("wrap_d10", DATA_OUT, 12'h00A);
      chk("wrap_empty", COUNT, 3'd0);

      // Reset mid-stream, between edges
      drive(1, 12'h105, 0, 0); tick();
      drive(1, 12'hAAA, 0, 0); tick();
      drive(1, 12'hBBB, 1, 0); tick();
      drive(0, 12'h000, 0, 0);
      chk("mr_pre_cnt", COUNT, 3'd2);
      chk("mr_pre_data", DATA_OUT, 12'h105);
      #2;
      REST = 1'b0;
      #1;
      chk("mr_data", DATA_OUT, 12'h000);
      chk("mr_valid", IR_VALID, 1'b0);
      chk("mr_count", COUNT, 3'd0);
      chk("mr_ready", FETCH_READY, 1'b1);
      tick();
      REST = 1'b1;

      // Randomized traffic, FETCH_VALID/DATA held while not accepted
      for (int c = 0; c < 3000; c++) begin
         if (!(FETCH_VALID && mq.size() >= DEPTH)) begin
            FETCH_VALID = ($urandom_range(0, 3) != 0);
            FETCH_DATA  = WIDTH'($urandom);
         end
         LOAD  = ($urandom_range(0, 1) == 1);
         FLUSH = ($urandom_range(0, 31) == 0);
         tick();
      end
      drive(0, 12'h000, 0, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
